// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mau_pkg
// Purpose  : Shared types and constants for the data-memory access unit.
// Revision : 1.0 - initial release
// ============================================================================
package mau_pkg;

    localparam int ADDR_W_DEF = 13;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mau_req_if / mau_mem_if
// Purpose  : Request/response channel and word-memory bus of the access unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mau_req_if;
    logic        Req_valid;
    logic        Req_ready;
    logic        Req_write;
    logic [1:0]  Req_size;
    logic        Req_signed;
    logic [31:0] Req_addr;
    logic [31:0] Req_wdata;
    logic        Resp_valid;
    logic [31:0] Resp_rdata;
    logic        Resp_err;

    modport master (
        output Req_valid, Req_write, Req_size, Req_signed, Req_addr, Req_wdata,
        input  Req_ready, Resp_valid, Resp_rdata, Resp_err
    );
    modport slave (
        input  Req_valid, Req_write, Req_size, Req_signed, Req_addr, Req_wdata,
        output Req_ready, Resp_valid, Resp_rdata, Resp_err
    );
endinterface

interface mau_mem_if import mau_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] Mem_addr;
    logic              Mem_read;
    logic              Mem_write;
    logic [31:0]       Mem_wdata;
    logic [31:0]       Mem_rdata;

    modport master (
        output Mem_addr, Mem_read, Mem_write, Mem_wdata,
        input  Mem_rdata
    );
    modport slave (
        input  Mem_addr, Mem_read, Mem_write, Mem_wdata,
        output Mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mau_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mau_lane_align
// Purpose  : Little-endian load extract/extend and sub-word store merge.
//            Merge port exists only when MAU_RMW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mau_lane_align import mau_pkg::*; (
    input  wire logic [1:0]  i_size,
    input  wire logic        i_signed,
    input  wire logic [1:0]  i_offset,
    input  wire logic [31:0] i_word,
`ifdef MAU_RMW_EN
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_merge,
`endif
    output logic      [31:0] o_load
);

    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = {i_offset, 3'b000};
    assign w_byte  = i_word[w_shift +: 8];
    assign w_half  = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        case (i_size)
            SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

`ifdef MAU_RMW_EN
    always_comb begin
        o_merge = i_word;
        case (i_size)
            SZ_BYTE: o_merge[w_shift +: 8] = i_wdata[7:0];
            SZ_HALF: begin
                if (i_offset[1]) o_merge[31:16] = i_wdata[15:0];
                else             o_merge[15:0]  = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store initiator for an 8K x 32 word memory; MAU_RMW_EN
//            enables read-modify-write sub-word stores.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit import mau_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic   Clk,
    input  wire logic   Rst_n,
    mau_req_if.slave    req,
    mau_mem_if.master   mem
);

    state_t            r_state;
    logic              r_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [31:0]       r_mem_wdata;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_offset;
`ifdef MAU_RMW_EN
    logic [31:0]       r_wdata;
    logic [31:0]       w_merge;
`endif
    logic [31:0]       w_load;
    logic              w_err;

    always_comb begin
        w_err = (req.Req_size == SZ_RSVD)
              | ((req.Req_size == SZ_HALF) & req.Req_addr[0])
              | ((req.Req_size == SZ_WORD) & (req.Req_addr[1:0] != 2'b00))
              | (|req.Req_addr[31:ADDR_W+2]);
`ifndef MAU_RMW_EN
        // Without RMW support a sub-word store cannot be performed at all.
        w_err = w_err | (req.Req_write & (req.Req_size != SZ_WORD));
`endif
    end

    mau_lane_align u_align (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_offset (r_offset),
        .i_word   (mem.Mem_rdata),
`ifdef MAU_RMW_EN
        .i_wdata  (r_wdata),
        .o_merge  (w_merge),
`endif
        .o_load   (w_load)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_mem_addr   <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_wdata  <= 32'h0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_offset     <= 2'b00;
`ifdef MAU_RMW_EN
            r_wdata      <= 32'h0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req.Req_valid) begin
                        r_ready    <= 1'b0;
                        r_size     <= req.Req_size;
                        r_signed   <= req.Req_signed;
                        r_offset   <= req.Req_addr[1:0];
                        r_mem_addr <= req.Req_addr[ADDR_W+1:2];
`ifdef MAU_RMW_EN
                        r_wdata    <= req.Req_wdata;
`endif
                        if (w_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!req.Req_write) begin
                            r_state    <= ST_RD;
                            r_mem_read <= 1'b1;
                        end else if (req.Req_size == SZ_WORD) begin
                            r_state     <= ST_WR;
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= req.Req_wdata;
                        end
`ifdef MAU_RMW_EN
                        else begin
                            r_state    <= ST_RMW_RD;
                            r_mem_read <= 1'b1;
                        end
`endif
                    end
                end
                ST_RD: begin
                    r_mem_read   <= 1'b0;
                    r_resp_rdata <= w_load;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_WR: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
`ifdef MAU_RMW_EN
                // Merge straight from the old word so the write cycle follows at once.
                ST_RMW_RD: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b1;
                    r_mem_wdata <= w_merge;
                    r_state     <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0;
                    r_ready      <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req.Req_ready  = r_ready;
    assign req.Resp_valid = r_resp_valid;
    assign req.Resp_err   = r_resp_err;
    assign req.Resp_rdata = r_resp_rdata;
    assign mem.Mem_addr   = r_mem_addr;
    assign mem.Mem_read   = r_mem_read;
    assign mem.Mem_write  = r_mem_write;
    assign mem.Mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench with a behavioural 8K x 32 memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic Clk;
    logic Rst_n;
    int   vectors;
    int   miscompares;

    mau_req_if             rq ();
    mau_mem_if #(.ADDR_W(13)) mm ();

    mem_access_unit #(.ADDR_W(13)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .req   (rq),
        .mem   (mm)
    );

    logic [31:0] mem_arr [0:8191];

    assign mm.Mem_rdata = mm.Mem_read ? mem_arr[mm.Mem_addr] : 32'h0;

    always @(posedge Clk) begin
        if (mm.Mem_write) mem_arr[mm.Mem_addr] <= mm.Mem_wdata;
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request, then measure latency and strobes up to the response cycle.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_rd, input int exp_wr,
                          input logic [31:0] exp_wdata, input logic [12:0] exp_maddr);
        int n;
        int lat;
        int rd_cnt;
        int wr_cnt;
        int both;
        logic [31:0] wdata_obs;
        @(negedge Clk);
        rq.Req_write  = wr;
        rq.Req_size   = sz;
        rq.Req_signed = sg;
        rq.Req_addr   = addr;
        rq.Req_wdata  = wd;
        rq.Req_valid  = 1'b1;
        n = 0;
        while (!rq.Req_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check({tag, " accept_wait"}, (n < 20) ? 32'd1 : 32'd0, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        rq.Req_valid = 1'b0;
        lat = 1; rd_cnt = 0; wr_cnt = 0; both = 0; wdata_obs = 32'h0;
        while (!rq.Resp_valid && lat < 10) begin
            if (mm.Mem_read) rd_cnt++;
            if (mm.Mem_write) begin
                wr_cnt++;
                wdata_obs = mm.Mem_wdata;
            end
            if (mm.Mem_read && mm.Mem_write) both++;
            @(negedge Clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, rq.Resp_rdata, exp_rdata);
        check({tag, " err"}, {31'd0, rq.Resp_err}, {31'd0, exp_err});
        check({tag, " reads"}, rd_cnt, exp_rd);
        check({tag, " writes"}, wr_cnt, exp_wr);
        check({tag, " rd_wr_overlap"}, both, 0);
        check({tag, " mem_addr"}, {19'd0, mm.Mem_addr}, {19'd0, exp_maddr});
        check({tag, " ready_in_resp"}, {31'd0, rq.Req_ready}, 32'd0);
        if (exp_wr != 0) check({tag, " wdata"}, wdata_obs, exp_wdata);
    endtask

    logic [31:0] exp_w10;

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst_n         = 1'b0;
        rq.Req_valid  = 1'b0;
        rq.Req_write  = 1'b0;
        rq.Req_size   = 2'b00;
        rq.Req_signed = 1'b0;
        rq.Req_addr   = 32'h0;
        rq.Req_wdata  = 32'h0;

        repeat (2) @(negedge Clk);
        check("rst ready",  {31'd0, rq.Req_ready},  32'd1);
        check("rst rvalid", {31'd0, rq.Resp_valid}, 32'd0);
        check("rst err",    {31'd0, rq.Resp_err},   32'd0);
        check("rst rdata",  rq.Resp_rdata,          32'd0);
        check("rst mread",  {31'd0, mm.Mem_read},   32'd0);
        check("rst mwrite", {31'd0, mm.Mem_write},  32'd0);
        check("rst maddr",  {19'd0, mm.Mem_addr},   32'd0);
        check("rst mwdata", mm.Mem_wdata,           32'd0);
        Rst_n = 1'b1;

        // Seed memory through the unit itself.
        do_req("sw 0x40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h8899AABB, 32'h0, 1'b0, 2, 0, 1, 32'h8899AABB, 13'h10);
        do_req("sw 0x44", 1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF, 13'h11);
        check("mem 0x10 seeded", mem_arr[16], 32'h8899AABB);

        do_req("lb 0x41", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0, 32'h0, 13'h10);
        do_req("lhu 0x42", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h00008899, 1'b0, 2, 1, 0, 32'h0, 13'h10);
        do_req("lh 0x42", 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0, 32'h0, 13'h10);
        do_req("lbu 0x43", 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'h00000088, 1'b0, 2, 1, 0, 32'h0, 13'h10);
        do_req("lbu 0x40", 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h000000BB, 1'b0, 2, 1, 0, 32'h0, 13'h10);
        do_req("lh 0x40", 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'hFFFFAABB, 1'b0, 2, 1, 0, 32'h0, 13'h10);
        do_req("lb 0x47", 1'b0, 2'b00, 1'b1, 32'h47, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0, 13'h11);
        do_req("lw 0x40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0, 32'h0, 13'h10);

`ifdef MAU_RMW_EN
        do_req("sb 0x40", 1'b1, 2'b00, 1'b0, 32'h40, 32'hFFFFFF55, 32'h0, 1'b0, 3, 1, 1, 32'h8899AA55, 13'h10);
        do_req("sh 0x42", 1'b1, 2'b01, 1'b0, 32'h42, 32'hABCD1234, 32'h0, 1'b0, 3, 1, 1, 32'h1234AA55, 13'h10);
        exp_w10 = 32'h1234AA55;
`else
        do_req("sb 0x40", 1'b1, 2'b00, 1'b0, 32'h40, 32'hFFFFFF55, 32'h0, 1'b1, 1, 0, 0, 32'h0, 13'h10);
        do_req("sh 0x42", 1'b1, 2'b01, 1'b0, 32'h42, 32'hABCD1234, 32'h0, 1'b1, 1, 0, 0, 32'h0, 13'h10);
        exp_w10 = 32'h8899AABB;
`endif
        do_req("lw after sub-store", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, exp_w10, 1'b0, 2, 1, 0, 32'h0, 13'h10);

        // Error cases: single-cycle response, no strobes.
        do_req("err lw 0x42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 13'h10);
        do_req("err lb 0x8000", 1'b0, 2'b00, 1'b0, 32'h8000, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 13'h0);
        do_req("err lh 0x41", 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 13'h10);
        do_req("err rsvd size", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 13'h10);
        do_req("err sw 0x8004", 1'b1, 2'b10, 1'b0, 32'h8004, 32'h12345678, 32'h0, 1'b1, 1, 0, 0, 32'h0, 13'h1);
        do_req("lw 0x7FFC top", 1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0, 32'hXXXXXXXX, 1'b0, 2, 1, 0, 32'h0, 13'h1FFF);

        // Reset during a word store's WR cycle, before the write edge.
        @(negedge Clk);
        rq.Req_write = 1'b1; rq.Req_size = 2'b10; rq.Req_signed = 1'b0;
        rq.Req_addr = 32'h44; rq.Req_wdata = 32'h11112222; rq.Req_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rq.Req_valid = 1'b0;
        check("rst-wr mwrite before", {31'd0, mm.Mem_write}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check("rst-wr mwrite async", {31'd0, mm.Mem_write}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst-wr ready", {31'd0, rq.Req_ready}, 32'd1);
        check("rst-wr word kept", mem_arr[17], 32'hDEADBEEF);

`ifdef MAU_RMW_EN
        // Reset during RMW_RD must never let the merged write through.
        @(negedge Clk);
        rq.Req_write = 1'b1; rq.Req_size = 2'b00; rq.Req_signed = 1'b0;
        rq.Req_addr = 32'h44; rq.Req_wdata = 32'h00000077; rq.Req_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rq.Req_valid = 1'b0;
        check("rst-rmw mread", {31'd0, mm.Mem_read}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check("rst-rmw mread async", {31'd0, mm.Mem_read}, 32'd0);
        @(negedge Clk);
        check("rst-rmw mwrite", {31'd0, mm.Mem_write}, 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst-rmw mwrite post", {31'd0, mm.Mem_write}, 32'd0);
        check("rst-rmw ready", {31'd0, rq.Req_ready}, 32'd1);
        check("rst-rmw word kept", mem_arr[17], 32'hDEADBEEF);
`endif

        // Back-to-back word stores with Req_valid held high.
        @(negedge Clk);
        rq.Req_write = 1'b1; rq.Req_size = 2'b10; rq.Req_signed = 1'b0;
        rq.Req_addr = 32'h48; rq.Req_wdata = 32'hA5A5A5A5; rq.Req_valid = 1'b1;
        check("b2b ready idle", {31'd0, rq.Req_ready}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        rq.Req_addr = 32'h4C; rq.Req_wdata = 32'h5A5A5A5A;
        check("b2b WR ready", {31'd0, rq.Req_ready}, 32'd0);
        check("b2b WR mwrite", {31'd0, mm.Mem_write}, 32'd1);
        check("b2b WR maddr", {19'd0, mm.Mem_addr}, 32'h12);
        @(negedge Clk);
        check("b2b RESP valid", {31'd0, rq.Resp_valid}, 32'd1);
        check("b2b RESP ready", {31'd0, rq.Req_ready}, 32'd0);
        @(negedge Clk);
        check("b2b IDLE ready", {31'd0, rq.Req_ready}, 32'd1);
        check("b2b IDLE mwrite", {31'd0, mm.Mem_write}, 32'd0);
        @(negedge Clk);
        rq.Req_valid = 1'b0;
        check("b2b WR2 mwrite", {31'd0, mm.Mem_write}, 32'd1);
        check("b2b WR2 maddr", {19'd0, mm.Mem_addr}, 32'h13);
        check("b2b WR2 wdata", mm.Mem_wdata, 32'h5A5A5A5A);
        @(negedge Clk);
        check("b2b RESP2 valid", {31'd0, rq.Resp_valid}, 32'd1);
        @(negedge Clk);
        check("b2b word 0x12", mem_arr[18], 32'hA5A5A5A5);
        check("b2b word 0x13", mem_arr[19], 32'h5A5A5A5A);
        check("b2b word 0x10", mem_arr[16], exp_w10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data-memory interface. It sits between the pipeline MEM stage and the word-organised 8K x 32 data memory.
- Accepts byte-addressed load/store requests of byte, halfword or word size.
- Drives the memory's Address/MemRead/MemWrite/Write_data and captures Read_data.
- Implements sub-word stores as read-modify-write.
- Returns aligned, optionally sign-extended load data with an error flag.

Parameters:
ADDR_W, 13, memory word-address width; the usable byte space is 2^(ADDR_W+2) bytes (32 KB).

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
Req_valid  input  1  request present
Req_ready  output  1  unit can accept a request (IDLE only)
Req_write  input  1  1 = store, 0 = load
Req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
Req_signed  input  1  sign-extend a sub-word load
Req_addr  input  32  byte address
Req_wdata  input  32  store data, right-justified
Resp_valid  output  1  one-cycle completion pulse
Resp_rdata  output  32  load result (0 for stores/errors)
Resp_err  output  1  misaligned, out-of-range or reserved size
Mem_addr  output  ADDR_W  word address = captured Req_addr[ADDR_W+1:2]
Mem_read  output  1  to memory MemRead
Mem_write  output  1  to memory MemWrite
Mem_wdata  output  32  to memory Write_data
Mem_rdata  input  32  from memory Read_data (combinational while Mem_read=1)

Behaviour:
- Clock and reset: single clock Clk; reset is asynchronous active-low on Rst_n. Reset forces IDLE; all outputs are 0 except Req_ready=1.
- Reset mid-operation: reset abandons any transaction at once. Mem_write drops asynchronously. A memory word changes only if a Clk edge with Mem_write=1 already occurred.
- Accept: a request is accepted on a Clk edge with Req_valid=1 and Req_ready=1. All Req_* fields are registered at accept. Req_ready=0 in every state except IDLE. The requester holds its request until accepted.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- Error check at accept: the request is an error if any of the following holds:
  - Req_size=11
  - a half access with addr[0]=1
  - a word access with addr[1:0]!=0
  - Req_addr[31:ADDR_W+2]!=0
- Error path: IDLE->RESP; Resp_err=1, Resp_rdata=0, no memory strobe. Latency 1.
- Load: IDLE->RD->RESP. In RD, Mem_read=1 and Mem_rdata is registered at the end of RD. Resp_valid is high in the RESP cycle, 2 cycles after accept.
- Word store: IDLE->WR->RESP. In WR, Mem_write=1 and Mem_wdata=wdata. Latency 2.
- Sub-word store: IDLE->RMW_RD->RMW_WR->RESP.
  - RMW_RD: Mem_read=1; the old word is captured.
  - RMW_WR: Mem_write=1 with the merged word. Latency 3.
- Lanes are little-endian; byte k occupies bits [8k+7:8k], k=addr[1:0].
  - Byte load: lane k is zero- or sign-extended per Req_signed.
  - Half load: bits [16h+15:16h] with h=addr[1], extended the same way.
  - Byte store merge: replaces lane k with wdata[7:0].
  - Half store merge: replaces half h with wdata[15:0].
- Mem_read and Mem_write are never high together. Mem_addr holds steady through RMW.
- RESP always returns to IDLE. Resp_rdata is 0 for stores. Resp_valid and Resp_err are held only in RESP; there is no response backpressure.

Optional Feature:
MAU_RMW_EN
- Defined: sub-word stores use the RMW path described above.
- Undefined: the RMW states are removed, and a sub-word store is treated as an error (Resp_err=1, latency 1, no memory access). Sub-word loads are unaffected.

Decomposition:
- Package mau_pkg: state encoding; size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD; ADDR_W default.
- Sub-module mau_lane_align (combinational): load extract/extend and store merge from (size, signed, addr[1:0], word, wdata).
- The FSM and registers stay in the top module.

Test Plan:
- Memory word 0x10 holds 0x8899AABB. Load byte, signed, addr 0x41 -> Resp_rdata=0xFFFFFFAA, Resp_valid 2 cycles after accept, Mem_addr=0x10.
- Same word. Load half, unsigned, addr 0x42 -> Resp_rdata=0x00008899.
- Word 0x10=0x8899AABB. Store byte 0x55 to addr 0x40 (MAU_RMW_EN) -> one Mem_read cycle, then Mem_write with Mem_wdata=0x8899AA55; Resp_valid 3 cycles after accept.
- Word load at addr 0x42, or any access at addr 0x8000 -> Resp_err=1 after 1 cycle, no Mem_read/Mem_write pulse.
- Assert Rst_n=0 during RMW_RD -> Mem_write stays 0, target word unchanged, Req_ready=1 after release.
- Back-to-back: Req_valid held high for two word stores -> second accepted only after RESP; Req_ready low during WR/RESP.
